// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto a single AXI3 master.
// Single-beat transactions only; each requester has at most one outstanding access.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  axi_arid,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {AR_IDLE, AR_INST, AR_DATA} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_ADDR, W_DATA} w_state_t;

    ar_state_t   ar_state_reg, ar_state_next;
    w_state_t    w_state_reg, w_state_next;
    logic        inst_busy_reg, inst_busy_next;
    logic        data_busy_reg, data_busy_next;
    logic        ready_reg;
    logic [31:0] ar_addr_reg, aw_addr_reg, wdata_reg;
    logic [1:0]  ar_size_reg, aw_size_reg;
    logic [3:0]  wstrb_reg;

    logic        data_rd_grant, inst_grant, store_grant;
    logic        inst_beat, data_r_beat, data_b_beat;

    // Inputs the bridge deliberately ignores.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bresp};

    // Read-address arbitration: a data read beats a fetch in the same cycle.
    always_comb begin
        ar_state_next = ar_state_reg;
        data_rd_grant = 1'b0;
        inst_grant    = 1'b0;
        case (ar_state_reg)
            AR_IDLE: begin
                if (data_sram_req && !data_sram_wr && !data_busy_reg) begin
                    data_rd_grant = 1'b1;
                    ar_state_next = AR_DATA;
                end else if (inst_sram_req && !inst_busy_reg) begin
                    inst_grant    = 1'b1;
                    ar_state_next = AR_INST;
                end
            end
            AR_INST, AR_DATA: begin
                if (arready) ar_state_next = AR_IDLE;
            end
            default: ar_state_next = AR_IDLE;
        endcase
    end

    // Write channel: AW and W handshake independently; leave once both have completed.
    always_comb begin
        w_state_next = w_state_reg;
        store_grant  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (data_sram_req && data_sram_wr && !data_busy_reg && !data_rd_grant) begin
                    store_grant  = 1'b1;
                    w_state_next = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                if (awready && wready) w_state_next = W_IDLE;
                else if (awready)      w_state_next = W_DATA;
                else if (wready)       w_state_next = W_ADDR;
            end
            W_ADDR:  if (awready) w_state_next = W_IDLE;
            W_DATA:  if (wready)  w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Responses are only forwarded to a requester that is actually waiting.
    assign inst_beat   = rvalid && (rid == INST_ID) && inst_busy_reg;
    assign data_r_beat = rvalid && (rid == DATA_ID) && data_busy_reg;
    assign data_b_beat = bvalid && (bid == DATA_ID) && data_busy_reg;

    always_comb begin
        inst_busy_next = inst_busy_reg;
        if (inst_grant)     inst_busy_next = 1'b1;
        else if (inst_beat) inst_busy_next = 1'b0;

        data_busy_next = data_busy_reg;
        if (data_rd_grant || store_grant)    data_busy_next = 1'b1;
        else if (data_r_beat || data_b_beat) data_busy_next = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_reg  <= AR_IDLE;
            w_state_reg   <= W_IDLE;
            inst_busy_reg <= 1'b0;
            data_busy_reg <= 1'b0;
            ready_reg     <= 1'b0;
            ar_addr_reg   <= 32'd0;
            ar_size_reg   <= 2'd0;
            aw_addr_reg   <= 32'd0;
            aw_size_reg   <= 2'd0;
            wstrb_reg     <= 4'd0;
            wdata_reg     <= 32'd0;
        end else begin
            ar_state_reg  <= ar_state_next;
            w_state_reg   <= w_state_next;
            inst_busy_reg <= inst_busy_next;
            data_busy_reg <= data_busy_next;
            ready_reg     <= 1'b1;
            if (data_rd_grant) begin
                ar_addr_reg <= data_sram_addr;
                ar_size_reg <= data_sram_size;
            end else if (inst_grant) begin
                ar_addr_reg <= inst_sram_addr;
                ar_size_reg <= inst_sram_size;
            end
            if (store_grant) begin
                aw_addr_reg <= data_sram_addr;
                aw_size_reg <= data_sram_size;
                wstrb_reg   <= data_sram_wstrb;
                wdata_reg   <= data_sram_wdata;
            end
        end
    end

    assign inst_sram_addr_ok = inst_grant;
    assign data_sram_addr_ok = data_rd_grant || store_grant;
    assign inst_sram_data_ok = inst_beat;
    assign inst_sram_rdata   = rdata;
    assign axi_arid          = inst_beat ? rid : 4'd0;
    assign data_sram_data_ok = data_r_beat || data_b_beat;
    assign data_sram_rdata   = rdata;

    assign arvalid = (ar_state_reg != AR_IDLE);
    assign arid    = (ar_state_reg == AR_DATA) ? DATA_ID : INST_ID;
    assign araddr  = ar_addr_reg;
    assign arsize  = {1'b0, ar_size_reg};
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = ready_reg;

    assign awvalid = (w_state_reg == W_ADDR_DATA) || (w_state_reg == W_ADDR);
    assign awid    = DATA_ID;
    assign awaddr  = aw_addr_reg;
    assign awsize  = {1'b0, aw_size_reg};
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wvalid  = (w_state_reg == W_ADDR_DATA) || (w_state_reg == W_DATA);
    assign wid     = DATA_ID;
    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign wlast   = 1'b1;
    assign bready  = ready_reg;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: drives core requests and AXI responses by hand,
// comparing outputs against hand-derived expectations.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  axi_arid;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .axi_arid(axi_arid),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        repeat (3) tick();
        settle();
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_araddr", araddr, 0);
        resetn = 1'b1;
        tick();
        settle();
        check_eq("rready_on", rready, 1);
        check_eq("bready_on", bready, 1);

        // Single fetch: addr_ok cycle 0, AR in cycle 1, data_ok in cycle 4
        tick();
        inst_sram_req = 1; inst_sram_size = 2; inst_sram_addr = 32'h1c000000;
        settle();
        check_eq("f_addr_ok", inst_sram_addr_ok, 1);
        check_eq("f_arvalid_c0", arvalid, 0);
        tick();
        inst_sram_req = 0; arready = 1;
        settle();
        check_eq("f_arvalid", arvalid, 1);
        check_eq("f_arid", arid, 0);
        check_eq("f_araddr", araddr, 32'h1c000000);
        check_eq("f_arsize", arsize, 2);
        check_eq("f_arlen", arlen, 0);
        check_eq("f_arburst", arburst, 1);
        tick();
        arready = 0;
        settle();
        check_eq("f_arvalid_done", arvalid, 0);
        tick();
        tick();
        rvalid = 1; rid = 0; rdata = 32'h02800404;
        settle();
        check_eq("f_data_ok", inst_sram_data_ok, 1);
        check_eq("f_rdata", inst_sram_rdata, 32'h02800404);
        check_eq("f_axi_arid", axi_arid, 0);
        check_eq("f_no_data_ok", data_sram_data_ok, 0);
        tick();
        rvalid = 0;

        // Fetch and load together: the load is granted first
        inst_sram_req = 1; inst_sram_size = 2; inst_sram_addr = 32'h1c000100;
        data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h1c010000;
        settle();
        check_eq("arb_data_ok", data_sram_addr_ok, 1);
        check_eq("arb_inst_ok", inst_sram_addr_ok, 0);
        tick();
        data_sram_req = 0; arready = 1;
        settle();
        check_eq("arb_arid_d", arid, 1);
        check_eq("arb_araddr_d", araddr, 32'h1c010000);
        check_eq("arb_inst_wait", inst_sram_addr_ok, 0);
        tick();
        arready = 0;
        settle();
        check_eq("arb_inst_ok2", inst_sram_addr_ok, 1);
        tick();
        inst_sram_req = 0; arready = 1;
        settle();
        check_eq("arb_arid_i", arid, 0);
        check_eq("arb_araddr_i", araddr, 32'h1c000100);
        tick();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h11112222;
        settle();
        check_eq("ld_data_ok", data_sram_data_ok, 1);
        check_eq("ld_rdata", data_sram_rdata, 32'h11112222);
        check_eq("ld_inst_quiet", inst_sram_data_ok, 0);
        tick();
        rid = 0; rdata = 32'h33334444;
        settle();
        check_eq("arb_f_data_ok", inst_sram_data_ok, 1);
        check_eq("arb_f_rdata", inst_sram_rdata, 32'h33334444);
        tick();
        rvalid = 0;

        // Store with AW accepted a cycle before W, load queued behind it
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_wstrb = 4'b0011;
        data_sram_addr = 32'h1c010004; data_sram_wdata = 32'h0000beef;
        settle();
        check_eq("st_addr_ok", data_sram_addr_ok, 1);
        tick();
        data_sram_req = 0; awready = 1;
        settle();
        check_eq("st_awvalid", awvalid, 1);
        check_eq("st_wvalid", wvalid, 1);
        check_eq("st_awaddr", awaddr, 32'h1c010004);
        check_eq("st_awsize", awsize, 2);
        tick();
        awready = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c010008;
        settle();
        check_eq("st_awvalid_off", awvalid, 0);
        check_eq("st_wvalid_hold", wvalid, 1);
        check_eq("st_wlast", wlast, 1);
        check_eq("st_wid", wid, 1);
        check_eq("st_wdata", wdata, 32'h0000beef);
        check_eq("st_wstrb", wstrb, 4'b0011);
        check_eq("raw_block0", data_sram_addr_ok, 0);
        wready = 1;
        tick();
        wready = 0;
        settle();
        check_eq("st_wvalid_off", wvalid, 0);
        check_eq("raw_block1", data_sram_addr_ok, 0);
        tick();
        bvalid = 1; bid = 1;
        settle();
        check_eq("st_b_data_ok", data_sram_data_ok, 1);
        check_eq("raw_block_b", data_sram_addr_ok, 0);
        tick();
        bvalid = 0;
        settle();
        check_eq("raw_ld_ok", data_sram_addr_ok, 1);
        tick();
        data_sram_req = 0; arready = 1;
        settle();
        check_eq("raw_araddr", araddr, 32'h1c010008);
        check_eq("raw_arid", arid, 1);
        tick();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'hcafe0001;
        settle();
        check_eq("raw_data_ok", data_sram_data_ok, 1);
        tick();
        rvalid = 0;

        // Fetch and store together, then inst R and B in the same cycle
        inst_sram_req = 1; inst_sram_addr = 32'h1c000200;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c010010; data_sram_wdata = 32'h12345678;
        data_sram_wstrb = 4'hf;
        settle();
        check_eq("dual_inst_ok", inst_sram_addr_ok, 1);
        check_eq("dual_store_ok", data_sram_addr_ok, 1);
        tick();
        inst_sram_req = 0; data_sram_req = 0; arready = 1; awready = 1; wready = 1;
        tick();
        arready = 0; awready = 0; wready = 0;
        rvalid = 1; rid = 0; rdata = 32'habcd0000; bvalid = 1; bid = 1;
        settle();
        check_eq("dual_inst_data_ok", inst_sram_data_ok, 1);
        check_eq("dual_data_data_ok", data_sram_data_ok, 1);
        tick();
        rvalid = 0; bvalid = 0;

        // Unexpected ID is dropped
        rvalid = 1; rid = 4'd5;
        settle();
        check_eq("badid_inst", inst_sram_data_ok, 0);
        check_eq("badid_data", data_sram_data_ok, 0);
        tick();
        rvalid = 0;

        // Reset with AR pending and not accepted
        inst_sram_req = 1; inst_sram_addr = 32'h1c000300;
        tick();
        inst_sram_req = 0;
        settle();
        check_eq("rst_pre_arvalid", arvalid, 1);
        resetn = 0;
        #1;
        check_eq("rst_async_arvalid", arvalid, 0);
        tick();
        resetn = 1;
        tick();
        rvalid = 1; rid = 0; rdata = 32'hdeadbeef;
        settle();
        check_eq("rst_no_stale_resp", inst_sram_data_ok, 0);
        tick();
        rvalid = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000400;
        settle();
        check_eq("rst_fresh_ok", inst_sram_addr_ok, 1);
        tick();
        inst_sram_req = 0;
        settle();
        check_eq("rst_fresh_araddr", araddr, 32'h1c000400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
